// File: rtl/icu186_wb.sv
// icu186_wb: Wishbone-slave 80186-style interrupt controller for the Zet core (io 0xFF20-0xFF3E).
//   Synchronises 4 maskable requests plus NMI, drives intr_o/nmi_o and returns the vector on inta/nmia.
//   Optional macro ICU_POLL_EN enables POLL (0xFF24, commits) and POLLST (0xFF26, no commit) reads.
// Ports: clk, rst (sync, active-high); wb_cyc_i/wb_stb_i/wb_we_i/wb_adr_i[3:0]/wb_sel_i/wb_dat_i ->
//   wb_dat_o/wb_ack_o (registered ack, one cycle after request); int_i[3:0], nmi_i async requests;
//   intr_o/inta_i and nmi_o/nmia_i CPU handshake; vec_o = {8'h00, vector type}.
module icu186_wb #(
   parameter logic [7:0] VEC_BASE    = 8'h0C,
   parameter logic [7:0] NMI_VEC     = 8'h02,
   parameter int         SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   input  logic        wb_we_i,
   input  logic [3:0]  wb_adr_i,
   input  logic [1:0]  wb_sel_i,
   input  logic [15:0] wb_dat_i,
   output logic [15:0] wb_dat_o,
   output logic        wb_ack_o,
   input  logic [3:0]  int_i,
   input  logic        nmi_i,
   output logic        intr_o,
   input  logic        inta_i,
   output logic        nmi_o,
   input  logic        nmia_i,
   output logic [15:0] vec_o
);

   logic [SYNC_STAGES-1:0][3:0] r_int_sync;
   logic [SYNC_STAGES-1:0]      r_nmi_sync;
   logic [3:0]  r_int_prev;
   logic        r_nmi_prev;
   logic [4:0]  r_ctl [4];          // [4] LTM, [3] MSK, [2:0] PR
   logic [2:0]  r_primsk;
   logic [3:0]  r_inserv;
   logic [3:0]  r_reqst;            // edge-mode latches only
   logic        r_ack, r_intr, r_nmi, r_inta_d, r_cand_vld;
   logic [1:0]  r_cand_idx;
   logic [7:0]  r_vec;
   logic [15:0] r_dat;

   logic [3:0]  w_int_s, w_int_rise, w_req, w_eoi_clr, w_commit_set;
   logic        w_nmi_rise, w_wb_req, w_wr, w_rd, w_inta_commit, w_poll_commit;
   logic        w_isr_vld, w_cand_vld;
   logic [1:0]  w_isr_idx, w_cand_idx;
   logic [3:0]  w_isr_min;
   logic [2:0]  w_cand_pr;
   logic [4:0]  w_eoi_idx;
   logic [7:0]  w_live_type;
   logic [15:0] w_rd_dat;
   logic        w_unused;

   assign w_unused   = ^{wb_sel_i, wb_dat_i[14:5]};
   assign w_int_s    = r_int_sync[SYNC_STAGES-1];
   assign w_int_rise = w_int_s & ~r_int_prev;
   assign w_nmi_rise = r_nmi_sync[SYNC_STAGES-1] & ~r_nmi_prev;

   always_comb begin
      for (int i = 0; i < 4; i++)
         w_req[i] = r_ctl[i][4] ? w_int_s[i] : r_reqst[i];
   end

   // Lowest in-service PR gates new candidates; its owner is also the nonspecific EOI target.
   always_comb begin
      w_isr_min  = 4'd8;
      w_isr_idx  = 2'd0;
      w_isr_vld  = 1'b0;
      w_cand_vld = 1'b0;
      w_cand_idx = 2'd0;
      w_cand_pr  = 3'd7;
      for (int i = 0; i < 4; i++) begin
         if (r_inserv[i] && ({1'b0, r_ctl[i][2:0]} < w_isr_min)) begin
            w_isr_min = {1'b0, r_ctl[i][2:0]};
            w_isr_idx = i[1:0];
            w_isr_vld = 1'b1;
         end
      end
      for (int i = 0; i < 4; i++) begin
         if (w_req[i] && !r_ctl[i][3] && (r_ctl[i][2:0] <= r_primsk) &&
             ({1'b0, r_ctl[i][2:0]} < w_isr_min) &&
             (!w_cand_vld || (r_ctl[i][2:0] < w_cand_pr))) begin
            w_cand_vld = 1'b1;
            w_cand_idx = i[1:0];
            w_cand_pr  = r_ctl[i][2:0];
         end
      end
   end

   assign w_live_type = w_cand_vld ? (VEC_BASE + {6'd0, w_cand_idx}) : (VEC_BASE + 8'd7);

   assign w_wb_req = wb_cyc_i & wb_stb_i & ~r_ack;
   assign w_wr     = w_wb_req & wb_we_i;
   assign w_rd     = w_wb_req & ~wb_we_i;

   always_comb begin
      w_rd_dat = 16'h0000;
      case (wb_adr_i)
`ifdef ICU_POLL_EN
         4'h2, 4'h3: w_rd_dat = {w_cand_vld, 10'b0, w_live_type[4:0]};
`endif
         4'h4: w_rd_dat = {12'b0, r_ctl[3][3], r_ctl[2][3], r_ctl[1][3], r_ctl[0][3]};
         4'h5: w_rd_dat = {13'b0, r_primsk};
         4'h6: w_rd_dat = {12'b0, r_inserv};
         4'h7: w_rd_dat = {12'b0, w_req};
         4'hC, 4'hD, 4'hE, 4'hF: w_rd_dat = {11'b0, r_ctl[wb_adr_i[1:0]]};
         default: w_rd_dat = 16'h0000;
      endcase
   end

`ifdef ICU_POLL_EN
   assign w_poll_commit = w_rd & (wb_adr_i == 4'h2) & w_cand_vld;
`else
   assign w_poll_commit = 1'b0;
`endif

   // inta commits the candidate frozen in r_vec, i.e. exactly what the CPU reads back.
   assign w_inta_commit = inta_i & ~r_inta_d & r_cand_vld;
   assign w_commit_set  = (w_inta_commit ? (4'b0001 << r_cand_idx) : 4'b0000) |
                          (w_poll_commit ? (4'b0001 << w_cand_idx) : 4'b0000);

   assign w_eoi_idx = wb_dat_i[4:0] - VEC_BASE[4:0];
   always_comb begin
      w_eoi_clr = 4'b0000;
      if (w_wr && (wb_adr_i == 4'h1)) begin
         if (wb_dat_i[15])
            w_eoi_clr = w_isr_vld ? (4'b0001 << w_isr_idx) : 4'b0000;
         else if (w_eoi_idx < 5'd4)
            w_eoi_clr = 4'b0001 << w_eoi_idx[1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_int_sync <= '0;
         r_nmi_sync <= '0;
         r_int_prev <= 4'b0000;
         r_nmi_prev <= 1'b0;
         for (int i = 0; i < 4; i++) r_ctl[i] <= 5'b01111;
         r_primsk   <= 3'd7;
         r_inserv   <= 4'b0000;
         r_reqst    <= 4'b0000;
         r_ack      <= 1'b0;
         r_dat      <= 16'h0000;
         r_intr     <= 1'b0;
         r_nmi      <= 1'b0;
         r_inta_d   <= 1'b1;        // an inta still high out of reset is not a new edge
         r_cand_vld <= 1'b0;
         r_cand_idx <= 2'd0;
         r_vec      <= 8'h00;
      end else begin
         r_int_sync <= {r_int_sync[SYNC_STAGES-2:0], int_i};
         r_nmi_sync <= {r_nmi_sync[SYNC_STAGES-2:0], nmi_i};
         r_int_prev <= w_int_s;
         r_nmi_prev <= r_nmi_sync[SYNC_STAGES-1];
         r_ack      <= w_wb_req;
         r_dat      <= w_rd ? w_rd_dat : 16'h0000;
         r_inta_d   <= inta_i;
         r_intr     <= w_cand_vld & ~inta_i;
         r_nmi      <= nmia_i ? 1'b0 : (w_nmi_rise | r_nmi);

         for (int i = 0; i < 4; i++) begin
            if (w_wr && (wb_adr_i == {2'b11, i[1:0]}))
               r_ctl[i] <= wb_dat_i[4:0];
            else if (w_wr && (wb_adr_i == 4'h4))
               r_ctl[i][3] <= wb_dat_i[i];
            // a new edge beats a same-cycle acknowledge
            if (r_ctl[i][4])
               r_reqst[i] <= 1'b0;
            else if (w_int_rise[i])
               r_reqst[i] <= 1'b1;
            else if (w_commit_set[i])
               r_reqst[i] <= 1'b0;
         end

         if (w_wr && (wb_adr_i == 4'h5))
            r_primsk <= wb_dat_i[2:0];

         // EOI clears before the commit sets
         if (w_wr && (wb_adr_i == 4'h6))
            r_inserv <= wb_dat_i[3:0] | w_commit_set;
         else
            r_inserv <= (r_inserv & ~w_eoi_clr) | w_commit_set;

         if (!inta_i && !nmia_i) begin
            r_vec      <= w_live_type;
            r_cand_vld <= w_cand_vld;
            r_cand_idx <= w_cand_idx;
         end
      end
   end

   assign wb_ack_o = r_ack;
   assign wb_dat_o = r_dat;
   assign intr_o   = r_intr;
   assign nmi_o    = r_nmi;
   assign vec_o    = {8'h00, nmia_i ? NMI_VEC : r_vec};

endmodule

// File: tb/tb_icu186_wb.sv
// tb_icu186_wb: directed bench for icu186_wb with hand-computed expectations.
//   Covers reset values, edge/level capture, priority and nesting, EOI, NMI, poll and reset mid-handshake.
//   POLL expectations follow ICU_POLL_EN, matching the build of the design.
module tb_icu186_wb;
   localparam int SYNC = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_cyc_i, wb_stb_i, wb_we_i;
   logic [3:0]  wb_adr_i;
   logic [1:0]  wb_sel_i;
   logic [15:0] wb_dat_i, wb_dat_o;
   logic        wb_ack_o;
   logic [3:0]  int_i;
   logic        nmi_i, intr_o, inta_i, nmi_o, nmia_i;
   logic [15:0] vec_o;
   logic [15:0] rdat;
   int          n_chk = 0;
   int          n_err = 0;
   int          ack_wait;

   always #5 clk = ~clk;

   icu186_wb #(.VEC_BASE(8'h0C), .NMI_VEC(8'h02), .SYNC_STAGES(SYNC)) dut (
      .clk(clk), .rst(rst),
      .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i), .wb_adr_i(wb_adr_i),
      .wb_sel_i(wb_sel_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
      .int_i(int_i), .nmi_i(nmi_i), .intr_o(intr_o), .inta_i(inta_i),
      .nmi_o(nmi_o), .nmia_i(nmia_i), .vec_o(vec_o)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wb_xfer(input logic we, input logic [3:0] adr, input logic [15:0] d,
                          output logic [15:0] q);
      int n;
      @(negedge clk);
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = d;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!wb_ack_o && n < 8);
      if (!wb_ack_o) chk("ack_timeout", 16'd0, 16'd1);
      ack_wait = n;
      q = wb_dat_o;
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
   endtask

   task automatic wr(input logic [3:0] adr, input logic [15:0] d);
      logic [15:0] dummy;
      wb_xfer(1'b1, adr, d, dummy);
   endtask

   task automatic rd_chk(input string tag, input logic [3:0] adr, input logic [15:0] exp);
      logic [15:0] q;
      wb_xfer(1'b0, adr, 16'h0000, q);
      chk(tag, q, exp);
   endtask

   task automatic pulse_inta();
      @(negedge clk); inta_i = 1'b1;
      @(negedge clk); inta_i = 1'b0;
   endtask

   // pulse int_i for one cycle, then wait (bounded) for intr_o
   task automatic raise_int(input logic [3:0] bits);
      @(negedge clk); int_i = int_i | bits;
      @(negedge clk); int_i = int_i & ~bits;
      for (int k = 0; k < SYNC + 2 && !intr_o; k++) @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; wb_adr_i = 0; wb_sel_i = 2'b11; wb_dat_i = 0;
      int_i = 0; nmi_i = 0; inta_i = 0; nmia_i = 0;
      repeat (3) @(negedge clk);
      chk("rst_intr", {15'd0, intr_o}, 16'd0);
      chk("rst_nmi",  {15'd0, nmi_o},  16'd0);
      chk("rst_vec",  vec_o, 16'h0000);
      rst = 1'b0;

      rd_chk("rst_ctl0", 4'hC, 16'h000F);
      chk("ack_latency", 16'(ack_wait), 16'd1);
      rd_chk("rst_primsk", 4'h5, 16'h0007);
      rd_chk("rst_inserv", 4'h6, 16'h0000);
      wr(4'h0, 16'hFFFF);
      rd_chk("unmapped", 4'h0, 16'h0000);

      // single edge source, ack and nonspecific EOI
      wr(4'hC, 16'h0000);
      raise_int(4'b0001);
      chk("s0_intr", {15'd0, intr_o}, 16'd1);
      chk("s0_vec", vec_o, 16'h000C);
      pulse_inta();
      chk("s0_intr_drop", {15'd0, intr_o}, 16'd0);
      rd_chk("s0_inserv", 4'h6, 16'h0001);
      rd_chk("s0_reqst", 4'h7, 16'h0000);
      wr(4'h1, 16'h8000);
      rd_chk("s0_eoi", 4'h6, 16'h0000);

      // priority and nesting: PR0=3, PR1=1, PR2=1
      wr(4'hC, 16'h0003);
      wr(4'hD, 16'h0001);
      wr(4'hE, 16'h0001);
      raise_int(4'b0111);
      chk("pri_intr", {15'd0, intr_o}, 16'd1);
      chk("pri_vec", vec_o, 16'h000D);
      pulse_inta();
      rd_chk("pri_inserv", 4'h6, 16'h0002);
      rd_chk("pri_reqst", 4'h7, 16'h0005);
      chk("pri_blocked", {15'd0, intr_o}, 16'd0);
      chk("pri_spur_vec", vec_o, 16'h0013);
      wr(4'h1, 16'h000D);
      @(negedge clk);
      chk("pri_next_vec", vec_o, 16'h000E);
      chk("pri_next_intr", {15'd0, intr_o}, 16'd1);

      // mask everything; a spurious ack changes nothing
      wr(4'h4, 16'h000F);
      rd_chk("mask_ctl0", 4'hC, 16'h000B);
      @(negedge clk);
      chk("mask_intr", {15'd0, intr_o}, 16'd0);
      pulse_inta();
      chk("spur_vec", vec_o, 16'h0013);
      rd_chk("spur_inserv", 4'h6, 16'h0000);

      // level mode source 1
      wr(4'hD, 16'h0011);
      int_i[1] = 1'b1;
      for (int k = 0; k < SYNC + 4 && !intr_o; k++) @(negedge clk);
      chk("lvl_intr", {15'd0, intr_o}, 16'd1);
      chk("lvl_vec", vec_o, 16'h000D);
      pulse_inta();
      rd_chk("lvl_inserv", 4'h6, 16'h0002);
      chk("lvl_intr_blk", {15'd0, intr_o}, 16'd0);
      wr(4'h1, 16'h8000);
      rd_chk("lvl_reqst", 4'h7, 16'h0007);
      chk("lvl_rereq", {15'd0, intr_o}, 16'd1);
      wr(4'h5, 16'h0000);
      @(negedge clk);
      chk("primsk_block", {15'd0, intr_o}, 16'd0);
      wr(4'h5, 16'h0007);
      int_i[1] = 1'b0;
      wr(4'hD, 16'h0009);

      // nmi edge while a maskable ack is in progress
      @(negedge clk); inta_i = 1'b1; nmi_i = 1'b1;
      @(negedge clk); nmi_i = 1'b0;
      for (int k = 0; k < SYNC + 2 && !nmi_o; k++) @(negedge clk);
      chk("nmi_set", {15'd0, nmi_o}, 16'd1);
      chk("nmi_inta_vec", vec_o, 16'h0013);
      inta_i = 1'b0;
      // nmia clears; an nmi edge landing while nmia is high is dropped
      @(negedge clk); nmia_i = 1'b1; nmi_i = 1'b1;
      #1 chk("nmia_vec", vec_o, 16'h0002);
      @(negedge clk); nmi_i = 1'b0;
      chk("nmia_clr", {15'd0, nmi_o}, 16'd0);
      repeat (3) @(negedge clk);
      nmia_i = 1'b0;
      repeat (3) @(negedge clk);
      chk("nmi_edge_ignored", {15'd0, nmi_o}, 16'd0);

      // source 3 at PR0, poll
      wr(4'hF, 16'h0000);
      raise_int(4'b1000);
      chk("s3_intr", {15'd0, intr_o}, 16'd1);
      chk("s3_vec", vec_o, 16'h000F);
`ifdef ICU_POLL_EN
      rd_chk("pollst", 4'h3, 16'h800F);
      rd_chk("pollst_inserv", 4'h6, 16'h0000);
      rd_chk("poll", 4'h2, 16'h800F);
      rd_chk("poll_inserv", 4'h6, 16'h0008);
`else
      rd_chk("poll_off", 4'h2, 16'h0000);
      rd_chk("pollst_off", 4'h3, 16'h0000);
      rd_chk("poll_off_inserv", 4'h6, 16'h0000);
`endif

      // reset while inta is high: state dropped, the pending ack ignored
      @(negedge clk); inta_i = 1'b1; rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      chk("rst_mid_intr", {15'd0, intr_o}, 16'd0);
      chk("rst_mid_nmi", {15'd0, nmi_o}, 16'd0);
      repeat (2) @(negedge clk);
      inta_i = 1'b0;
      rd_chk("rst_mid_inserv", 4'h6, 16'h0000);
      rd_chk("rst_mid_ctl3", 4'hF, 16'h000F);
      rd_chk("rst_mid_reqst", 4'h7, 16'h0000);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
